// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-cache requests with a req/hit
// handshake, stalls upstream latches until the cache answers, tracks the
// LL/SC link register (snoop-invalidatable) and latches the processor halt.
module mem_access_stage #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OFFSET_BITS = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              valid_in,
    input  logic              ren_in,
    input  logic              wen_in,
    input  logic              ll_in,
    input  logic              sc_in,
    input  logic              halt_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdat_in,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dload,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              dREN,
    output logic              dWEN,
    output logic [ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0] dstore,
    output logic              stall,
    output logic              memwb_enable,
    output logic [DATA_W-1:0] result_out,
    output logic              halted
);

    localparam int WA_W = ADDR_W - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_ren_q, req_ren_d;
    logic              req_wen_q, req_wen_d;
    logic              req_sc_q, req_sc_d;
    logic              req_ll_q, req_ll_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdat_q, req_wdat_d;
    logic              link_valid_q, link_valid_d;
    logic [WA_W-1:0]   link_addr_q, link_addr_d;

    // Word-granular address views; byte offsets never matter for the link.
    logic [WA_W-1:0] addr_in_word;
    logic [WA_W-1:0] snoop_word;
    logic [WA_W-1:0] req_word;
    logic            unused_snoop_offset;

    assign addr_in_word        = addr_in[ADDR_W-1:OFFSET_BITS];
    assign snoop_word          = snoop_addr[ADDR_W-1:OFFSET_BITS];
    assign req_word            = req_addr_q[ADDR_W-1:OFFSET_BITS];
    assign unused_snoop_offset = ^snoop_addr[OFFSET_BITS-1:0];

    logic snoop_hits_link;
    logic snoop_hits_req;
    logic sc_fails;

    // A snoop hitting the current link kills it, even in the cycle an SC is judged.
    assign snoop_hits_link = snoop_inv && link_valid_q && (snoop_word == link_addr_q);
    assign snoop_hits_req  = snoop_inv && (snoop_word == req_word);
    assign sc_fails        = !link_valid_q || (addr_in_word != link_addr_q) || snoop_hits_link;

    // State, request and link registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            req_ren_q    <= 1'b0;
            req_wen_q    <= 1'b0;
            req_sc_q     <= 1'b0;
            req_ll_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdat_q   <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_ren_q    <= req_ren_d;
            req_wen_q    <= req_wen_d;
            req_sc_q     <= req_sc_d;
            req_ll_q     <= req_ll_d;
            req_addr_q   <= req_addr_d;
            req_wdat_q   <= req_wdat_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    // Next-state, request latching, link update and pipeline-control outputs.
    always_comb begin
        logic ll_done;
        logic clear_link;

        state_d      = state_q;
        req_ren_d    = req_ren_q;
        req_wen_d    = req_wen_q;
        req_sc_d     = req_sc_q;
        req_ll_d     = req_ll_q;
        req_addr_d   = req_addr_q;
        req_wdat_d   = req_wdat_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        daddr        = '0;
        dstore       = '0;
        stall        = 1'b0;
        memwb_enable = 1'b1;
        result_out   = '0;
        ll_done      = 1'b0;
        clear_link   = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in && halt_in) begin
                    state_d = HALTED;
                end else if (valid_in && wen_in && sc_in && sc_fails) begin
                    // Failed SC retires immediately with status 0 and no request.
                    clear_link = 1'b1;
                end else if (valid_in && (ren_in || wen_in)) begin
                    req_ren_d    = ren_in;
                    req_wen_d    = wen_in;
                    req_sc_d     = sc_in;
                    req_ll_d     = ll_in;
                    req_addr_d   = addr_in;
                    req_wdat_d   = wdat_in;
                    stall        = 1'b1;
                    memwb_enable = 1'b0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                dREN   = req_ren_q;
                dWEN   = req_wen_q;
                daddr  = req_addr_q;
                dstore = req_wdat_q;
                if (dhit) begin
                    if (req_ren_q) begin
                        result_out = dload;
                    end else begin
                        result_out = {{(DATA_W-1){1'b0}}, req_sc_q};
                    end
                    ll_done    = req_ll_q;
                    clear_link = req_sc_q;
                    req_ren_d  = 1'b0;
                    req_wen_d  = 1'b0;
                    req_sc_d   = 1'b0;
                    req_ll_d   = 1'b0;
                    req_addr_d = '0;
                    req_wdat_d = '0;
                    state_d    = IDLE;
                end else begin
                    stall        = 1'b1;
                    memwb_enable = 1'b0;
                end
            end
            HALTED: begin
                stall        = 1'b1;
                memwb_enable = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completing LL installs a new link unless a snoop on that same word
        // arrives in the same cycle; otherwise snoops on the old link clear it.
        if (ll_done) begin
            link_valid_d = !snoop_hits_req;
            link_addr_d  = req_word;
        end else if (clear_link || snoop_hits_link) begin
            link_valid_d = 1'b0;
        end
    end

    assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed LL/SC/snoop/halt/reset
// scenarios plus a randomized op stream checked against an op-level model.
module tb_mem_access_stage;

    logic        CLK;
    logic        nRST;
    logic        valid_in, ren_in, wen_in, ll_in, sc_in, halt_in;
    logic [31:0] addr_in, wdat_in;
    logic        dhit;
    logic [31:0] dload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        dREN, dWEN;
    logic [31:0] daddr, dstore;
    logic        stall, memwb_enable;
    logic [31:0] result_out;
    logic        halted;

    int n_checks;
    int n_fail;

    // Reference model of the link register (word address).
    bit          m_lv;
    logic [29:0] m_la;

    mem_access_stage #(.ADDR_W(32), .DATA_W(32), .OFFSET_BITS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .valid_in(valid_in), .ren_in(ren_in), .wen_in(wen_in),
        .ll_in(ll_in), .sc_in(sc_in), .halt_in(halt_in),
        .addr_in(addr_in), .wdat_in(wdat_in),
        .dhit(dhit), .dload(dload),
        .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .stall(stall), .memwb_enable(memwb_enable),
        .result_out(result_out), .halted(halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [29:0] word(input logic [31:0] a);
        return a[31:2];
    endfunction

    task automatic clear_inputs();
        valid_in = 0; ren_in = 0; wen_in = 0; ll_in = 0; sc_in = 0; halt_in = 0;
        addr_in = 0; wdat_in = 0; dhit = 0; dload = 0; snoop_inv = 0; snoop_addr = 0;
    endtask

    // One memory instruction: presented in IDLE, request held for lat cycles,
    // then completed by dhit. Optional snoops in the issue and the dhit cycle.
    task automatic do_op(input string name, input bit is_ren, input bit is_wen,
                         input bit is_ll, input bit is_sc,
                         input logic [31:0] addr, input logic [31:0] wdat,
                         input int lat, input bit snp_n, input bit snp_d,
                         input logic [31:0] snp_addr);
        bit          exp_req;
        bit          succ;
        logic [31:0] rdata;
        logic [31:0] exp_res;
        succ    = m_lv && (word(addr) == m_la) && !(snp_n && word(snp_addr) == m_la);
        exp_req = !(is_sc && !succ);
        rdata   = $urandom;
        exp_res = is_ren ? rdata : (is_sc && exp_req ? 32'd1 : 32'd0);

        @(posedge CLK); #1;
        valid_in = 1; ren_in = is_ren; wen_in = is_wen; ll_in = is_ll; sc_in = is_sc;
        halt_in = 0; addr_in = addr; wdat_in = wdat; dhit = 0;
        snoop_inv = snp_n; snoop_addr = snp_addr;
        #1;
        n_checks++;
        if ({dREN, dWEN, stall, memwb_enable} !== {1'b0, 1'b0, exp_req, !exp_req}) begin
            n_fail++;
            $display("FAIL %s issue_ctrl: got dREN/dWEN/stall/memwb=%b%b%b%b want 00%b%b",
                     name, dREN, dWEN, stall, memwb_enable, exp_req, !exp_req);
        end
        if (is_sc && !succ) m_lv = 0;
        if (snp_n && m_lv && word(snp_addr) == m_la) m_lv = 0;

        if (!exp_req) begin
            n_checks++;
            if (result_out !== 32'd0) begin
                n_fail++;
                $display("FAIL %s sc_fail_result: got %h want 0", name, result_out);
            end
            $display("op %s addr=%h no-request result=%h", name, addr, result_out);
            return;
        end

        for (int i = 0; i < lat; i++) begin
            @(posedge CLK); #1;
            snoop_inv = 0;
            #1;
            n_checks++;
            if ({dREN, dWEN, daddr, dstore, stall, memwb_enable} !==
                {is_ren, is_wen, addr, wdat, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL %s wait_req: got dREN=%b dWEN=%b daddr=%h dstore=%h stall=%b memwb=%b want %b %b %h %h 1 0",
                         name, dREN, dWEN, daddr, dstore, stall, memwb_enable, is_ren, is_wen, addr, wdat);
            end
        end

        @(posedge CLK); #1;
        dhit = 1; dload = rdata; snoop_inv = snp_d; snoop_addr = snp_addr;
        #1;
        n_checks++;
        if ({dREN, dWEN, daddr, dstore, stall, memwb_enable, result_out} !==
            {is_ren, is_wen, addr, wdat, 1'b0, 1'b1, exp_res}) begin
            n_fail++;
            $display("FAIL %s hit_cycle: got dREN=%b dWEN=%b daddr=%h stall=%b memwb=%b result=%h want %b %b %h 0 1 %h",
                     name, dREN, dWEN, daddr, stall, memwb_enable, result_out, is_ren, is_wen, addr, exp_res);
        end
        if (is_ll) begin
            m_la = word(addr);
            m_lv = !(snp_d && word(snp_addr) == word(addr));
        end else begin
            if (is_sc) m_lv = 0;
            if (snp_d && m_lv && word(snp_addr) == m_la) m_lv = 0;
        end
        $display("op %s addr=%h lat=%0d result=%h expected=%h", name, addr, lat, result_out, exp_res);
    endtask

    task automatic idle_cycle(input bit snp, input logic [31:0] snp_addr);
        @(posedge CLK); #1;
        clear_inputs();
        snoop_inv = snp; snoop_addr = snp_addr;
        if (snp && m_lv && word(snp_addr) == m_la) m_lv = 0;
        #1;
        n_checks++;
        if ({dREN, dWEN, stall, memwb_enable, result_out} !== {1'b0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL idle_cycle: got dREN=%b dWEN=%b stall=%b memwb=%b result=%h want 0 0 0 1 0",
                     dREN, dWEN, stall, memwb_enable, result_out);
        end
        $display("idle snoop=%b addr=%h", snp, snp_addr);
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 0;
        m_lv = 0; m_la = 0;
        #12;
        n_checks++;
        if ({dREN, dWEN, daddr, dstore, halted, stall, memwb_enable, result_out} !==
            {1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got dREN=%b dWEN=%b daddr=%h dstore=%h halted=%b stall=%b memwb=%b result=%h",
                     dREN, dWEN, daddr, dstore, halted, stall, memwb_enable, result_out);
        end
        $display("reset asserted");
        @(posedge CLK); #1;
        nRST = 1;
        idle_cycle(0, 0);
    endtask

    task automatic test_load();
        do_op("load", 1, 0, 0, 0, 32'h100, 32'h0, 3, 0, 0, 0);
        idle_cycle(0, 0);
    endtask

    task automatic test_store();
        do_op("store", 0, 1, 0, 0, 32'h204, 32'h12345678, 0, 0, 0, 0);
        idle_cycle(0, 0);
    endtask

    task automatic test_llsc();
        do_op("ll", 1, 0, 1, 0, 32'h300, 32'h0, 1, 0, 0, 0);
        do_op("sc_ok", 0, 1, 0, 1, 32'h300, 32'hAAAA5555, 1, 0, 0, 0);
        do_op("sc_again", 0, 1, 0, 1, 32'h300, 32'hAAAA5555, 1, 0, 0, 0);
        idle_cycle(0, 0);
    endtask

    task automatic test_snoop();
        do_op("ll", 1, 0, 1, 0, 32'h300, 32'h0, 0, 0, 0, 0);
        idle_cycle(1, 32'h302);
        do_op("sc_snooped", 0, 1, 0, 1, 32'h300, 32'h1111, 0, 0, 0, 0);
        do_op("ll", 1, 0, 1, 0, 32'h300, 32'h0, 0, 0, 0, 0);
        idle_cycle(1, 32'h304);
        do_op("sc_other_word", 0, 1, 0, 1, 32'h300, 32'h2222, 0, 0, 0, 0);
        idle_cycle(0, 0);
    endtask

    task automatic test_simultaneous();
        do_op("ll_snoop_hit", 1, 0, 1, 0, 32'h300, 32'h0, 1, 0, 1, 32'h301);
        do_op("sc_after_ll_snoop", 0, 1, 0, 1, 32'h300, 32'h3333, 0, 0, 0, 0);
        do_op("ll", 1, 0, 1, 0, 32'h300, 32'h0, 0, 0, 0, 0);
        do_op("sc_same_cycle_snoop", 0, 1, 0, 1, 32'h300, 32'h4444, 0, 1, 0, 32'h303);
        do_op("ll", 1, 0, 1, 0, 32'h300, 32'h0, 0, 0, 0, 0);
        do_op("sc_snoop_elsewhere", 0, 1, 0, 1, 32'h300, 32'h5555, 0, 1, 0, 32'h308);
        idle_cycle(0, 0);
    endtask

    // Randomized back-to-back op stream over a few neighbouring words.
    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [31:0] a;
            logic [31:0] sa;
            kind = $urandom_range(0, 3);
            a    = 32'h300 | $urandom_range(0, 11);
            sa   = 32'h300 | $urandom_range(0, 11);
            case (kind)
                0: do_op("rnd_load", 1, 0, 0, 0, a, $urandom, $urandom_range(0, 3),
                         $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, sa);
                1: do_op("rnd_store", 0, 1, 0, 0, a, $urandom, $urandom_range(0, 3),
                         $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, sa);
                2: do_op("rnd_ll", 1, 0, 1, 0, a, $urandom, $urandom_range(0, 3),
                         $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, sa);
                default: do_op("rnd_sc", 0, 1, 0, 1, a, $urandom, $urandom_range(0, 3),
                               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, sa);
            endcase
            if ($urandom_range(0, 4) == 0) idle_cycle($urandom_range(0, 1), sa);
        end
        idle_cycle(0, 0);
    endtask

    task automatic test_reset_mid_request();
        do_op("ll", 1, 0, 1, 0, 32'h300, 32'h0, 0, 0, 0, 0);
        @(posedge CLK); #1;
        clear_inputs();
        valid_in = 1; ren_in = 1; addr_in = 32'h100;
        @(posedge CLK); #1;
        valid_in = 0; ren_in = 0;
        #1;
        n_checks++;
        if ({dREN, daddr} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL pre_reset_req: got dREN=%b daddr=%h want 1 00000100", dREN, daddr);
        end
        nRST = 0;
        #1;
        n_checks++;
        if ({dREN, dWEN, daddr, dstore, stall, memwb_enable, halted} !==
            {1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got dREN=%b dWEN=%b daddr=%h dstore=%h stall=%b memwb=%b halted=%b",
                     dREN, dWEN, daddr, dstore, stall, memwb_enable, halted);
        end
        $display("reset mid-request dREN=%b", dREN);
        m_lv = 0; m_la = 0;
        @(posedge CLK); #1;
        nRST = 1;
        do_op("sc_after_reset", 0, 1, 0, 1, 32'h300, 32'h6666, 0, 0, 0, 0);
        idle_cycle(0, 0);
    endtask

    task automatic test_halt();
        @(posedge CLK); #1;
        clear_inputs();
        valid_in = 1; halt_in = 1;
        #1;
        n_checks++;
        if ({memwb_enable, stall, halted} !== {1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_issue: got memwb=%b stall=%b halted=%b want 1 0 0",
                     memwb_enable, stall, halted);
        end
        $display("halt issued");
        @(posedge CLK); #1;
        halt_in = 0; ren_in = 1; addr_in = 32'h100;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_checks++;
            if ({halted, stall, memwb_enable, dREN, dWEN} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL halted_hold cycle %0d: got halted=%b stall=%b memwb=%b dREN=%b dWEN=%b",
                         i, halted, stall, memwb_enable, dREN, dWEN);
            end
            @(posedge CLK); #1;
        end
        $display("halt held 20 cycles");
        clear_inputs();
        nRST = 0;
        #1;
        n_checks++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: got halted=%b want 0", halted);
        end
        @(posedge CLK); #1;
        nRST = 1;
        m_lv = 0;
        idle_cycle(0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load();
        test_store();
        test_llsc();
        test_snoop();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_request();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage sitting between the EX/MEM pipeline latch and the MEM/WB latch. It issues data-cache read/write requests with a request/hit handshake and stalls the pipeline until the cache answers. It also implements LL/SC with a link register that coherence snoops can invalidate, and latches the processor halt. It drives the MEM/WB latch's load-data input and enable.

## Interface
- ADDR_W, 32, data address width
- DATA_W, 32, data word width
- OFFSET_BITS, 2, low address bits ignored in link-address compare (word granularity)

- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- valid_in  in  1  EX/MEM holds a valid instruction
- ren_in, wen_in  in  1  load / store (includes LL, SC)
- ll_in, sc_in  in  1  instruction is LL / SC (set together with ren_in / wen_in)
- halt_in  in  1  instruction is HALT
- addr_in  in  ADDR_W  effective address
- wdat_in  in  DATA_W  store data
- dhit  in  1  cache completes the current request this cycle
- dload  in  DATA_W  cache read data, valid when dhit=1
- snoop_inv  in  1  coherence invalidation this cycle
- snoop_addr  in  ADDR_W  invalidated address
- dREN, dWEN  out  1  cache read / write request
- daddr  out  ADDR_W  request address
- dstore  out  DATA_W  request write data
- stall  out  1  hold the PC, IF/ID, ID/EX and EX/MEM latches
- memwb_enable  out  1  MEM/WB latch enable
- result_out  out  DATA_W  load data / SC status, to MEM/WB dmemload_in
- halted  out  1  processor halted (sticky)

## Operation
- States: IDLE, REQ, HALTED. Registers: state, req_ren, req_wen, req_sc, req_ll, req_addr, req_wdat, link_valid, link_addr.
- IDLE, valid_in=0 or no memory op: stall=0, memwb_enable=1, result_out=0, no request.
- IDLE, valid_in & halt_in: memwb_enable=1 for that cycle; next state HALTED.
- IDLE, valid_in & (ren_in | wen_in), not a failing SC: latch the request fields; stall=1, memwb_enable=0; next state REQ.
- An SC fails when link_valid=0, or addr_in[ADDR_W-1:OFFSET_BITS] != link_addr. A failing SC issues no request. In the same cycle: result_out=0, stall=0, memwb_enable=1, link_valid cleared.
- REQ: dREN=req_ren, dWEN=req_wen, daddr=req_addr, dstore=req_wdat. All are held constant until dhit.
  - dhit=0: stall=1, memwb_enable=0.
  - dhit=1: stall=0, memwb_enable=1; next state IDLE.
  - result_out on dhit: dload for a read, 1 for an SC, 0 for a plain store.
- LL completing on dhit: link_valid=1, link_addr=req_addr[ADDR_W-1:OFFSET_BITS].
- SC completing on dhit: link_valid cleared.
- snoop_inv with a word-address match to link_addr clears link_valid in any state.
- Simultaneous events:
  - Snoop and LL completion on the same word in the same cycle: the snoop wins and link_valid ends 0.
  - Snoop matching in the same cycle an SC is evaluated in IDLE: the SC fails.
- HALTED: no requests, stall=1, memwb_enable=0, halted=1. Left only by reset.
- Request outputs are zero whenever the state is not REQ.

## Timing
- Reset (asynchronous) forces the following immediately, including mid-request: state IDLE, link_valid=0, link_addr=0, all req_* registers 0, dREN=dWEN=0, daddr=dstore=0, halted=0.
- After reset, with valid_in=0: stall=0, memwb_enable=1, result_out=0.
- Request latency: op present in cycle N (IDLE); dREN/dWEN asserted from cycle N+1. Minimum total is 2 cycles, with dhit in N+1.
- result_out is combinational from dload in the dhit cycle. MEM/WB captures it at the end of that cycle.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after dhit. There is one non-request cycle between requests.
- A failing SC and non-memory ops take 1 cycle with no stall.

## Test plan
- Load: addr_in=0x100, ren_in=1; dhit=1 with dload=0xDEADBEEF three cycles after dREN rises -> stall=1 for 4 cycles, dREN=1 with daddr=0x100 for 3 cycles, then result_out=0xDEADBEEF with memwb_enable=1 in the dhit cycle.
- Store: addr_in=0x204, wdat_in=0x12345678, dhit the cycle after the request -> dWEN=1 for 1 cycle, dstore=0x12345678, result_out=0.
- LL to 0x300, then SC to 0x300 -> SC issues dWEN and result_out=1. A second SC to 0x300 -> no dWEN, result_out=0, stall=0.
- LL to 0x300, then snoop_inv with snoop_addr=0x302, then SC to 0x300 -> SC fails with result_out=0 and no request. Repeat with snoop_addr=0x304 -> SC succeeds.
- Halt: halt_in with valid_in=1 -> memwb_enable=1 for that cycle, then halted=1, stall=1, memwb_enable=0 held for 20 cycles. Any later ren_in produces no dREN.
- Reset mid-request: nRST low while in REQ with dREN=1 -> dREN=0 asynchronously. After release: IDLE, link_valid=0, and an SC fails.
